// File: rtl/ip_frame_tx_pkg.sv
// Shared constants for the IPv4 frame transmitter: header length, default
// header contents and the transmit state encoding.
package ip_frame_tx_pkg;

  localparam logic [4:0]  HDR_LEN_DEF = 5'd20;
  localparam int unsigned HDR_BYTES   = 20;

  localparam logic [7:0]  VER_IHL_DEF = 8'h45;
  localparam logic [7:0]  TTL_DEF     = 8'h40;
  localparam logic [7:0]  PROTO_UDP   = 8'h11;
  localparam logic [31:0] INIT_SRCIP  = 32'hC0A8_0104;
  localparam logic [31:0] INIT_DSTIP  = 32'hC0A8_0105;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_HDR     = 4'b0010,
    S_PAYLOAD = 4'b0100,
    S_DONE    = 4'b1000
  } state_e;

  // Power-on header: no length/id/checksum yet, DF set, UDP, default IPs.
  function automatic logic [7:0] hdr_default(input logic [4:0] idx);
    logic [7:0] b;
    b = '0;
    case (idx)
      5'd0:  b = VER_IHL_DEF;
      5'd6:  b = 8'h40;
      5'd8:  b = TTL_DEF;
      5'd9:  b = PROTO_UDP;
      5'd12: b = INIT_SRCIP[31:24];
      5'd13: b = INIT_SRCIP[23:16];
      5'd14: b = INIT_SRCIP[15:8];
      5'd15: b = INIT_SRCIP[7:0];
      5'd16: b = INIT_DSTIP[31:24];
      5'd17: b = INIT_DSTIP[23:16];
      5'd18: b = INIT_DSTIP[15:8];
      5'd19: b = INIT_DSTIP[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ip_frame_tx_hdr_regfile.sv
// 20x8 IPv4 header buffer: single write port, reset to default header,
// combinational read mux.
module ip_hdr_regfile
  import ip_frame_tx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_idx,
  input  logic [7:0] i_wr_byte,
  input  logic [4:0] i_rd_idx,
  output logic [7:0] o_rd_byte
);

  logic [7:0] mem_q [HDR_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < HDR_BYTES; i++) begin
        mem_q[i] <= hdr_default(5'(i));
      end
    end else if (i_wr_en && (i_wr_idx < HDR_LEN_DEF)) begin
      mem_q[i_wr_idx] <= i_wr_byte;
    end
  end

  assign o_rd_byte = (i_rd_idx < HDR_LEN_DEF) ? mem_q[i_rd_idx] : '0;

endmodule

// File: rtl/ip_frame_tx.sv
// Streams the buffered IPv4 header followed by the payload bytes as one
// valid/ready byte stream with sop/eop framing.
module ip_frame_tx
  import ip_frame_tx_pkg::*;
#(
  parameter logic [15:0] PAYLOAD_MAX = 16'd1480,
  parameter logic [4:0]  HDR_LEN     = HDR_LEN_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_iph_idx,
  input  logic [7:0]  i_iph_byte,
  input  logic        i_wr_iph_en,
  input  logic        i_hdr_ready,
  input  logic        i_start,
  input  logic [15:0] i_data_length,
  input  logic [7:0]  i_pl_byte,
  input  logic        i_pl_valid,
  output logic        o_pl_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  state_e      state_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] len_q;
  logic        hdr_valid_q;
  logic        err_q;

  logic        busy;
  logic        wr_accept;
  logic [7:0]  hdr_rd_byte;
  logic [15:0] hdr_last_idx;

  assign busy         = (state_q == S_HDR) || (state_q == S_PAYLOAD);
  assign wr_accept    = i_wr_iph_en && !busy && (i_iph_idx < HDR_LEN);
  assign hdr_last_idx = {11'd0, HDR_LEN} - 16'd1;

  ip_hdr_regfile u_hdr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_wr_iph_en && !busy),
    .i_wr_idx  (i_iph_idx),
    .i_wr_byte (i_iph_byte),
    .i_rd_idx  (byte_cnt_q[4:0]),
    .o_rd_byte (hdr_rd_byte)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      len_q       <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= i_wr_iph_en && busy;
      if (wr_accept) hdr_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && hdr_valid_q && !i_wr_iph_en) begin
            if (i_data_length > PAYLOAD_MAX) begin
              err_q <= 1'b1;
            end else begin
              len_q       <= i_data_length;
              byte_cnt_q  <= '0;
              hdr_valid_q <= 1'b0;
              state_q     <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (i_tx_ready) begin
            if (byte_cnt_q == hdr_last_idx) begin
              byte_cnt_q <= '0;
              state_q    <= (len_q == '0) ? S_DONE : S_PAYLOAD;
            end else begin
              byte_cnt_q <= byte_cnt_q + 16'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (i_pl_valid && i_tx_ready) begin
            if (byte_cnt_q == len_q - 16'd1) begin
              byte_cnt_q <= '0;
              state_q    <= S_DONE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 16'd1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // A header-complete strobe overrides any clear in the same cycle.
      if (i_hdr_ready) hdr_valid_q <= 1'b1;
    end
  end

  always_comb begin
    o_tx_byte  = '0;
    o_tx_valid = 1'b0;
    o_pl_ready = 1'b0;
    if (state_q == S_HDR) begin
      o_tx_byte  = hdr_rd_byte;
      o_tx_valid = 1'b1;
    end else if (state_q == S_PAYLOAD) begin
      o_tx_byte  = i_pl_byte;
      o_tx_valid = i_pl_valid;
      o_pl_ready = i_tx_ready;
    end
  end

  assign o_tx_sop = (state_q == S_HDR) && (byte_cnt_q == '0);
  assign o_tx_eop = ((state_q == S_HDR) && (byte_cnt_q == hdr_last_idx) && (len_q == '0)) ||
                    ((state_q == S_PAYLOAD) && (byte_cnt_q == len_q - 16'd1));
  assign o_busy   = busy;
  assign o_done   = (state_q == S_DONE);
  assign o_err    = err_q;

endmodule
